// File: rtl/simon_round_ctrl.sv
// Round controller for the memory game: grows a pattern one value per round, plays it
// out to the display stage, then checks the player's key presses against it.
module simon_round_ctrl #(
  parameter int MAX_LEN     = 16,
  parameter int SHOW_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] seq_in,
  output logic       go_to_next_seq,
  output logic       show_valid,
  output logic [3:0] show_value,
  input  logic       player_valid,
  input  logic [3:0] player_key,
  output logic [4:0] round_len,
  output logic       await_input,
  output logic       win,
  output logic       lose
);

  localparam int IW   = $clog2(MAX_LEN);
  localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_CAPTURE,
    S_SHOW_ON,
    S_SHOW_GAP,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      round_len_q, round_len_d;
  logic [IW-1:0]   index_q, index_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      pat_q [MAX_LEN];
  logic [3:0]      pat_d [MAX_LEN];

  logic [4:0]      len_m1;
  logic [IW-1:0]   wr_idx;
  logic            idx_is_last;
  logic            show_done;
  logic            gap_done;
  logic            key_match;

  assign len_m1      = round_len_q - 5'd1;
  assign wr_idx      = len_m1[IW-1:0];
  assign idx_is_last = (5'(index_q) == len_m1);
  assign show_done   = (timer_q == SHOW_LAST);
  assign gap_done    = (timer_q == GAP_LAST);
  assign key_match   = (player_key == pat_q[index_q]);

  always_comb begin
    state_d     = state_q;
    round_len_d = round_len_q;
    index_d     = index_q;
    timer_d     = timer_q;
    pat_d       = pat_q;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          round_len_d = 5'd1;
          index_d     = '0;
          timer_d     = '0;
          state_d     = S_GEN;
        end
      end

      S_GEN: begin
        state_d = S_CAPTURE;
      end

      // seq_in is valid now, one cycle after the advance pulse
      S_CAPTURE: begin
        pat_d[wr_idx] = seq_in;
        index_d       = '0;
        timer_d       = '0;
        state_d       = S_SHOW_ON;
      end

      S_SHOW_ON: begin
        if (show_done) begin
          timer_d = '0;
          state_d = S_SHOW_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_SHOW_GAP: begin
        if (gap_done) begin
          timer_d = '0;
          if (idx_is_last) begin
            index_d = '0;
            state_d = S_INPUT;
          end else begin
            index_d = index_q + IW'(1);
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // start is deliberately not looked at here, so a coincident start is dropped
      S_INPUT: begin
        if (player_valid) begin
          if (!key_match) begin
            state_d = S_LOSE;
          end else if (!idx_is_last) begin
            index_d = index_q + IW'(1);
          end else if (round_len_q == LEN_MAX) begin
            state_d = S_WIN;
          end else begin
            round_len_d = round_len_q + 5'd1;
            index_d     = '0;
            state_d     = S_GEN;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      round_len_q <= 5'd0;
      index_q     <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      round_len_q <= round_len_d;
      index_q     <= index_d;
      timer_q     <= timer_d;
    end
  end

  // Pattern storage carries no reset; entries are always written before being read
  always_ff @(posedge clk) begin
    pat_q <= pat_d;
  end

  assign go_to_next_seq = (state_q == S_GEN);
  assign show_valid     = (state_q == S_SHOW_ON);
  assign show_value     = (state_q == S_SHOW_ON) ? pat_q[index_q] : 4'd0;
  assign round_len      = (state_q == S_IDLE) ? 5'd0 : round_len_q;
  assign await_input    = (state_q == S_INPUT);
  assign win            = (state_q == S_WIN);
  assign lose           = (state_q == S_LOSE);

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: timeline-based reference model compared every cycle,
// plus directed literal checks on key points of each scenario.
module tb_simon_round_ctrl;

  localparam int MAXL  = 4;
  localparam int SHOWC = 3;
  localparam int GAPC  = 2;
  localparam int PER   = SHOWC + GAPC;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_IN   = 2;
  localparam int P_WIN  = 3;
  localparam int P_LOSE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] seq_in;
  logic       go_to_next_seq;
  logic       show_valid;
  logic [3:0] show_value;
  logic       player_valid;
  logic [3:0] player_key;
  logic [4:0] round_len;
  logic       await_input;
  logic       win;
  logic       lose;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [3:0] gen_list [12] = '{4'hA, 4'h3, 4'h7, 4'hC, 4'h5, 4'hE,
                                4'h2, 4'h9, 4'h6, 4'h1, 4'h4, 4'h8};
  int gen_ptr = 0;

  simon_round_ctrl #(
    .MAX_LEN    (MAXL),
    .SHOW_CYCLES(SHOWC),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .seq_in        (seq_in),
    .go_to_next_seq(go_to_next_seq),
    .show_valid    (show_valid),
    .show_value    (show_value),
    .player_valid  (player_valid),
    .player_key    (player_key),
    .round_len     (round_len),
    .await_input   (await_input),
    .win           (win),
    .lose          (lose)
  );

  always #5 clk = ~clk;

  // sequence_gen stand-in: a new value appears the cycle after each advance pulse
  always @(negedge clk) begin
    if (go_to_next_seq === 1'b1) begin
      seq_in = gen_list[gen_ptr];
      gen_ptr++;
    end
  end

  // Reference model: tracks game phase and the cycle each round's advance pulse fires;
  // the display schedule is derived arithmetically from that start cycle
  int         cyc = 0;
  int         t0 = 0;
  int         m_len = 0;
  int         m_idx = 0;
  int         m_gen = 0;
  int         m_phase = P_IDLE;
  logic [3:0] m_pat [$];

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_phase = P_IDLE;
      m_len   = 0;
      m_idx   = 0;
      m_pat.delete();
    end else begin
      if (m_phase == P_IDLE || m_phase == P_WIN || m_phase == P_LOSE) begin
        if (start) begin
          m_pat.delete();
          m_pat.push_back(gen_list[m_gen]);
          m_gen++;
          m_len   = 1;
          t0      = cyc;
          m_phase = P_RUN;
        end
      end else if (m_phase == P_IN && player_valid) begin
        if (player_key != m_pat[m_idx]) begin
          m_phase = P_LOSE;
        end else if (m_idx < m_len - 1) begin
          m_idx++;
        end else if (m_len == MAXL) begin
          m_phase = P_WIN;
        end else begin
          m_len++;
          m_pat.push_back(gen_list[m_gen]);
          m_gen++;
          t0      = cyc;
          m_phase = P_RUN;
        end
      end
      if (m_phase == P_RUN && (cyc - t0) == 2 + m_len * PER) begin
        m_phase = P_IN;
        m_idx   = 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int         off;
    int         k;
    int         r;
    logic       e_go;
    logic       e_sv;
    logic [3:0] e_val;
    logic [4:0] e_len;
    logic [13:0] act;
    logic [13:0] exp_v;
    if (chk_en) begin
      e_go  = 1'b0;
      e_sv  = 1'b0;
      e_val = 4'd0;
      if (m_phase == P_RUN) begin
        off  = cyc - t0;
        e_go = (off == 0);
        if (off >= 2) begin
          k = (off - 2) / PER;
          r = (off - 2) % PER;
          if (k < m_len && r < SHOWC) begin
            e_sv  = 1'b1;
            e_val = m_pat[k];
          end
        end
      end
      e_len = (m_phase == P_IDLE) ? 5'd0 : 5'(m_len);
      act   = {go_to_next_seq, show_valid, show_value, round_len, await_input, win, lose};
      exp_v = {e_go, e_sv, e_val, e_len, m_phase == P_IN, m_phase == P_WIN, m_phase == P_LOSE};
      n_assert++;
      if (act !== exp_v) begin
        n_fail++;
        $display("[TB] FAIL cycle_model @%0d: got go/sv/val/len/await/win/lose=%b/%b/%h/%0d/%b/%b/%b, expected %b/%b/%h/%0d/%b/%b/%b",
                 cyc, act[13], act[12], act[11:8], act[7:3], act[2], act[1], act[0],
                 exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one cycle of inputs, returning in the cycle that reflects them
  task automatic applyStimulus(input logic s, input logic v, input logic [3:0] key);
    @(negedge clk);
    start        = s;
    player_valid = v;
    player_key   = key;
    @(negedge clk);
    start        = 1'b0;
    player_valid = 1'b0;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_assert++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic waitAwait(input int maxc);
    int n;
    n = 0;
    while (await_input !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (await_input !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL await_timeout: got await_input=%b after %0d cycles, expected 1", await_input, n);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    seq_in       = 4'd0;
    player_valid = 1'b0;
    player_key   = 4'd0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");

    tick(20);
    checkOutput("idle_round_len", 8'(round_len), 8'd0);
    checkOutput("idle_outputs", {1'b0, go_to_next_seq, show_valid, show_value, await_input, win, lose}, 8'd0);

    // Game 1, round 1: value A
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("r1_go", 8'(go_to_next_seq), 8'd1);
    tick(2);
    checkOutput("r1_show_valid", 8'(show_valid), 8'd1);
    checkOutput("r1_show_value", 8'(show_value), 8'hA);
    tick(3);
    checkOutput("r1_gap", 8'(show_valid), 8'd0);
    tick(2);
    checkOutput("r1_await", 8'(await_input), 8'd1);
    checkOutput("r1_len", 8'(round_len), 8'd1);

    // Round 2: value 3, with a stray key press during the display
    applyStimulus(1'b0, 1'b1, 4'hA);
    checkOutput("r2_go", 8'(go_to_next_seq), 8'd1);
    checkOutput("r2_len", 8'(round_len), 8'd2);
    tick(3);
    applyStimulus(1'b0, 1'b1, 4'h5);
    checkOutput("r2_show_ignore", 8'(lose), 8'd0);
    waitAwait(40);
    applyStimulus(1'b0, 1'b1, 4'hA);
    applyStimulus(1'b0, 1'b1, 4'h3);
    checkOutput("r3_go", 8'(go_to_next_seq), 8'd1);
    checkOutput("r3_len", 8'(round_len), 8'd3);

    // Round 3 (A,3,7): wrong second key loses
    waitAwait(40);
    applyStimulus(1'b0, 1'b1, 4'hA);
    checkOutput("lose_pre", 8'(lose), 8'd0);
    applyStimulus(1'b0, 1'b1, 4'h5);
    checkOutput("lose_set", 8'(lose), 8'd1);
    checkOutput("lose_await", 8'(await_input), 8'd0);
    applyStimulus(1'b0, 1'b1, 4'h3);
    checkOutput("lose_hold", 8'(lose), 8'd1);

    // Game 2: C,5,E,2 played through to a win
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("g2_len", 8'(round_len), 8'd1);
    waitAwait(40);
    applyStimulus(1'b1, 1'b1, 4'hC);
    checkOutput("g2_start_drop_go", 8'(go_to_next_seq), 8'd1);
    checkOutput("g2_start_drop_len", 8'(round_len), 8'd2);
    for (int rl = 2; rl <= MAXL; rl++) begin
      waitAwait(40);
      for (int i = 0; i < rl; i++) applyStimulus(1'b0, 1'b1, gen_list[3 + i]);
    end
    checkOutput("win_set", 8'(win), 8'd1);
    checkOutput("win_len", 8'(round_len), 8'd4);
    checkOutput("win_await", 8'(await_input), 8'd0);
    applyStimulus(1'b0, 1'b1, 4'hC);
    checkOutput("win_hold", 8'(win), 8'd1);

    // Restart, then reset during the display
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("restart_go", 8'(go_to_next_seq), 8'd1);
    checkOutput("restart_len", 8'(round_len), 8'd1);
    checkOutput("restart_win", 8'(win), 8'd0);
    tick(3);
    checkOutput("mid_show_value", 8'(show_value), 8'h9);
    resetPulse();
    checkOutput("rst_show_valid", 8'(show_valid), 8'd0);
    checkOutput("rst_show_len", 8'(round_len), 8'd0);

    // Reset while waiting for input
    applyStimulus(1'b1, 1'b0, 4'h0);
    waitAwait(40);
    resetPulse();
    checkOutput("rst_input_await", 8'(await_input), 8'd0);
    checkOutput("rst_input_len", 8'(round_len), 8'd0);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
